// File: rtl/npc_pkg.sv
// Shared constants and types for the next-PC unit.
package npc_pkg;
  localparam int unsigned XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  localparam int unsigned REDIR_BR   = 0;
  localparam int unsigned REDIR_JALR = 1;
  localparam int unsigned REDIR_JAL  = 2;

  typedef logic [XLEN_DEF-1:0] addr_t;
endpackage

// File: rtl/npc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating count.
// push/pop arrive already qualified; pop is only asserted when count > 0.
module npc_ras
  import npc_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic [CW-1:0]   count
);
  logic [DEPTH-1:0][XLEN-1:0] mem;
  logic [PW-1:0]              top_ptr;
  logic [PW-1:0]              wr_ptr;

  // Push+pop replaces the top in place; a lone push lands above it,
  // which on a full stack is the oldest slot.
  assign wr_ptr = pop ? top_ptr : top_ptr + PW'(1);
  assign top    = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          top_ptr <= top_ptr + PW'(1);
          if (count != CW'(DEPTH)) count <= count + CW'(1);
        end
        2'b01: begin
          top_ptr <= top_ptr - PW'(1);
          count   <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/npc_unit.sv
// Next-PC unit: prioritised redirects, stall hold, optional RAS prediction, PC+4.
// Define NPC_RAS_EN to build in the return-address stack.
module npc_unit
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned     REDIR_N   = 3,
  parameter int unsigned     RAS_DEPTH = 4,
  localparam int unsigned    CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [REDIR_N-1:0]      redir_valid,
  input  logic [REDIR_N*XLEN-1:0] redir_target,
  input  logic                    ras_push,
  input  logic [XLEN-1:0]         ras_push_addr,
  input  logic                    ras_pop,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         pc_plus4,
  output logic [XLEN-1:0]         npc,
  output logic                    ras_hit,
  output logic [CW-1:0]           ras_count
);
  logic            redir_any;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] ras_top;

  assign pc_plus4 = pc + XLEN'(4);

  // Descending scan so the lowest asserted channel is the final assignment.
  always_comb begin
    redir_any = 1'b0;
    redir_pc  = '0;
    for (int i = REDIR_N - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_any = 1'b1;
        redir_pc  = redir_target[i*XLEN +: XLEN];
      end
    end
  end

`ifdef NPC_RAS_EN
  logic push_q;
  logic pop_q;

  assign push_q  = ras_push && !stall;
  assign pop_q   = ras_pop && !stall && !redir_any && (ras_count != '0);
  assign ras_hit = pop_q;

  npc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_addr (ras_push_addr),
    .pop       (pop_q),
    .top       (ras_top),
    .count     (ras_count)
  );
`else
  logic unused_ras;

  assign unused_ras = ^{ras_push, ras_push_addr, ras_pop};
  assign ras_hit    = 1'b0;
  assign ras_count  = '0;
  assign ras_top    = '0;
`endif

  always_comb begin
    if (redir_any)    npc = redir_pc;
    else if (stall)   npc = pc;
    else if (ras_hit) npc = ras_top;
    else              npc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= npc;
  end
endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: stimulus queues expected outputs per cycle, monitor checks at negedge.
module tb_npc_unit;
  localparam int XLEN = 32;
  localparam int RN   = 3;
`ifdef NPC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [RN-1:0]     redir_valid;
  logic [RN*XLEN-1:0] redir_target;
  logic              ras_push;
  logic [XLEN-1:0]   ras_push_addr;
  logic              ras_pop;
  logic [XLEN-1:0]   pc, pc_plus4, npc;
  logic              ras_hit;
  logic [2:0]        ras_count;

  typedef struct {
    string           name;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            hit;
    logic [2:0]      cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  npc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .npc           (npc),
    .ras_hit       (ras_hit),
    .ras_count     (ras_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || npc !== e.npc || pc_plus4 !== e.pc + 32'd4 ||
          ras_hit !== e.hit || ras_count !== e.cnt) begin
        failures++;
        $display("FAIL %s: got pc=%h npc=%h pc4=%h hit=%b cnt=%0d exp pc=%h npc=%h pc4=%h hit=%b cnt=%0d",
                 e.name, pc, npc, pc_plus4, ras_hit, ras_count,
                 e.pc, e.npc, e.pc + 32'd4, e.hit, e.cnt);
      end
    end
  end

  task automatic idle();
    rst = 1'b0; stall = 1'b0; redir_valid = '0; redir_target = '0;
    ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
  endtask

  task automatic redir(input int ch, input logic [XLEN-1:0] t);
    redir_valid[ch] = 1'b1;
    redir_target[ch*XLEN +: XLEN] = t;
  endtask

  // Queue the expectation for the current input set, then advance one edge.
  task automatic cyc(input string name, input logic [XLEN-1:0] epc, input logic [XLEN-1:0] enpc,
                     input logic ehit, input logic [2:0] ecnt);
    exp_t e;
    e.name = name; e.pc = epc; e.npc = enpc; e.hit = ehit; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk); #1;
    idle();
  endtask

  function automatic logic [XLEN-1:0] sel(input logic [XLEN-1:0] r, input logic [XLEN-1:0] n);
    return RAS ? r : n;
  endfunction

  function automatic logic [2:0] c(input logic [2:0] r);
    return RAS ? r : 3'd0;
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    cyc("reset", 32'h0, 32'h4, 1'b0, 3'd0);
    cyc("free0", 32'h0, 32'h4, 1'b0, 3'd0);
    cyc("free1", 32'h4, 32'h8, 1'b0, 3'd0);
    cyc("free2", 32'h8, 32'hC, 1'b0, 3'd0);
    redir(0, 32'h100);
    cyc("redir_br", 32'hC, 32'h100, 1'b0, 3'd0);
    stall = 1'b1; redir(1, 32'h200); redir(2, 32'h300);
    cyc("prio_ch1", 32'h100, 32'h200, 1'b0, 3'd0);
    stall = 1'b1;
    cyc("stall_hold", 32'h200, 32'h200, 1'b0, 3'd0);
    cyc("after_stall", 32'h200, 32'h204, 1'b0, 3'd0);
    redir(2, 32'hFFFF_FFFC);
    cyc("redir_jal", 32'h204, 32'hFFFF_FFFC, 1'b0, 3'd0);
    cyc("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 3'd0);
    cyc("post_wrap", 32'h0, 32'h4, 1'b0, 3'd0);
    rst = 1'b1; stall = 1'b1; redir(0, 32'h500);
    cyc("rst_vs_redir", 32'h4, 32'h500, 1'b0, 3'd0);
    cyc("rst_wins", 32'h0, 32'h4, 1'b0, 3'd0);

    // Two pushes, two hits, one pop on empty.
    ras_push = 1'b1; ras_push_addr = 32'hA0;
    cyc("push_a0", 32'h4, 32'h8, 1'b0, 3'd0);
    ras_push = 1'b1; ras_push_addr = 32'hB0;
    cyc("push_b0", 32'h8, 32'hC, 1'b0, c(3'd1));
    ras_pop = 1'b1;
    cyc("pop_b0", 32'hC, sel(32'hB0, 32'h10), RAS, c(3'd2));
    ras_pop = 1'b1;
    cyc("pop_a0", sel(32'hB0, 32'h10), sel(32'hA0, 32'h14), RAS, c(3'd1));
    ras_pop = 1'b1;
    cyc("pop_empty", sel(32'hA0, 32'h14), sel(32'hA4, 32'h18), 1'b0, 3'd0);
    redir(0, 32'h1000);
    cyc("resync0", sel(32'hA4, 32'h18), 32'h1000, 1'b0, 3'd0);

    // Overflow: fifth push overwrites the oldest entry.
    ras_push = 1'b1; ras_push_addr = 32'h10;
    cyc("push10", 32'h1000, 32'h1004, 1'b0, 3'd0);
    ras_push = 1'b1; ras_push_addr = 32'h20;
    cyc("push20", 32'h1004, 32'h1008, 1'b0, c(3'd1));
    ras_push = 1'b1; ras_push_addr = 32'h30;
    cyc("push30", 32'h1008, 32'h100C, 1'b0, c(3'd2));
    ras_push = 1'b1; ras_push_addr = 32'h40;
    cyc("push40", 32'h100C, 32'h1010, 1'b0, c(3'd3));
    ras_push = 1'b1; ras_push_addr = 32'h50;
    cyc("push50_full", 32'h1010, 32'h1014, 1'b0, c(3'd4));
    ras_pop = 1'b1;
    cyc("ovf_pop50", 32'h1014, sel(32'h50, 32'h1018), RAS, c(3'd4));
    ras_pop = 1'b1;
    cyc("ovf_pop40", sel(32'h50, 32'h1018), sel(32'h40, 32'h101C), RAS, c(3'd3));
    ras_pop = 1'b1;
    cyc("ovf_pop30", sel(32'h40, 32'h101C), sel(32'h30, 32'h1020), RAS, c(3'd2));
    ras_pop = 1'b1;
    cyc("ovf_pop20", sel(32'h30, 32'h1020), sel(32'h20, 32'h1024), RAS, c(3'd1));
    redir(0, 32'h2000);
    cyc("resync1", sel(32'h20, 32'h1024), 32'h2000, 1'b0, 3'd0);

    // Redirect suppresses the pop; push+pop replaces the top.
    ras_push = 1'b1; ras_push_addr = 32'h77;
    cyc("push77", 32'h2000, 32'h2004, 1'b0, 3'd0);
    ras_pop = 1'b1; redir(0, 32'h3000);
    cyc("pop_vs_redir", 32'h2004, 32'h3000, 1'b0, c(3'd1));
    cyc("cnt_kept", 32'h3000, 32'h3004, 1'b0, c(3'd1));
    ras_push = 1'b1; ras_push_addr = 32'h88; ras_pop = 1'b1;
    cyc("push_pop", 32'h3004, sel(32'h77, 32'h3008), RAS, c(3'd1));
    ras_pop = 1'b1;
    cyc("pop_replaced", sel(32'h77, 32'h3008), sel(32'h88, 32'h300C), RAS, c(3'd1));
    stall = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h99;
    cyc("stall_push", sel(32'h88, 32'h300C), sel(32'h88, 32'h300C), 1'b0, 3'd0);
    cyc("stall_no_push", sel(32'h88, 32'h300C), sel(32'h8C, 32'h3010), 1'b0, 3'd0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
